// File: rtl/request_encoder.sv
// Sequential 8-to-3 priority encoder: sticky pending register feeding a two-state
// grant FSM that presents the highest-index pending request until acknowledged.
module request_encoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [2:0] code_next;
  logic       valid_next;
  logic [7:0] pending_next;
  logic [7:0] clr;

  // Index of the most significant set bit; callers guarantee v is non-zero.
  function automatic logic [2:0] highest_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    code_next  = code;
    valid_next = valid;
    clr        = 8'h00;

    unique case (state)
      IDLE: begin
        if (pending != 8'h00) begin
          code_next  = highest_index(pending);
          valid_next = 1'b1;
          state_next = PRESENT;
        end else begin
          valid_next = 1'b0;
        end
      end
      PRESENT: begin
        // The grant is frozen here; a higher-priority arrival waits for the next IDLE pass.
        if (ack) begin
          clr        = 8'h01 << code;
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase

    // Set after clear so a request re-arriving on its own ack edge survives.
    pending_next = (pending & ~clr) | (en ? req : 8'h00);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      code    <= 3'd0;
      valid   <= 1'b0;
      pending <= 8'h00;
    end else begin
      state   <= state_next;
      code    <= code_next;
      valid   <= valid_next;
      pending <= pending_next;
    end
  end

endmodule

// File: doc/request_encoder.md
# request_encoder

Sequential 8-to-3 priority encoder, the encoding counterpart of the team's 3-to-8 enable decoder. Latches one-hot/multi-hot request lines into a sticky pending register, presents the highest-index pending request as a registered 3-bit code with a valid flag, and holds it until acknowledged. It sits between raw request sources (buttons, switches, event strobes) and any consumer that needs a binary index, such as a decoder driving outputs or a display.

## Interface
- No parameters; width fixed at 8 requests / 3-bit code.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  capture enable; when 0, new requests are ignored and already-pending requests are still served.
- req  input  8  request lines; req[7] highest priority, req[0] lowest.
- ack  input  1  consumer acknowledge of the presented code; meaningful only while valid=1.
- code  output  3  binary index of the granted request; registered.
- valid  output  1  code holds a granted request; registered.
- pending  output  8  current sticky pending register.

## Operation
- Pending register: each edge, pending <= (pending & ~clr) | (en ? req : 8'h00).
  - clr is a one-hot mask of code, active only on the edge where state=PRESENT and ack=1; otherwise 0.
  - Set wins over clear: if req[code]=1 and en=1 on the ack edge, pending[code] stays 1.
- Two-state FSM, state register reset to IDLE.
  - IDLE: if pending != 0 (register value, not req), load code with the index of the highest set bit of pending, set valid=1, go to PRESENT. Otherwise hold: valid=0, code unchanged.
  - PRESENT: code and valid are held stable regardless of req or pending changes, including a higher-priority arrival. On ack=1: clear pending[code], set valid=0, go to IDLE.
- ack while IDLE (valid=0) is ignored: no pending bits are cleared and the state is unchanged.
- Priority is fixed and non-rotating. A continuously re-asserted high request starves lower ones.
- Multi-hot req is legal. All asserted bits are captured, then served one per grant in descending index order.
- Reset values: pending=8'h00, code=3'b000, valid=0, state=IDLE. Reset asserted mid-PRESENT drops valid asynchronously and discards all pending requests.

## Timing
- Request-to-valid latency: 2 edges when idle. req is sampled at edge N, so pending is set after N; the FSM loads at edge N+1, so valid=1 after N+1.
- Ack-to-next-grant: ack sampled at edge M, so valid=0 after M. If other bits are pending, the next grant has valid=1 after M+1. This is a guaranteed one-cycle bubble between grants; valid is never high for two consecutive grants without a low cycle.
- Maximum throughput: one grant per 2 cycles.
- code changes only on IDLE->PRESENT edges. It is stable while valid=1 and retains its last value while valid=0.
- Reset assertion affects outputs with no clock required. Deassertion is synchronous to the design; the first capture happens at the first rising edge after deassertion.

## Test plan
- Reset: assert reset mid-PRESENT with pending=8'hA5 -> immediately valid=0, code=0, pending=0. After release with req=0, outputs stay unchanged for 5 cycles.
- Single request: one-cycle pulse req=8'h10, en=1 -> pending=8'h10 after edge 1, valid=1 and code=4 after edge 2. Hold ack=0 for 4 cycles -> outputs stable. Pulse ack -> valid=0, pending=0.
- Multi-hot ordering: one-cycle pulse req=8'b1000_0101, ack asserted whenever valid=1 -> grants code=7, 2, 0 in order, each separated by one valid=0 cycle, ending with pending=0.
- Preemption hold: grant code=1 is presented, then req=8'h80 arrives -> code stays 1 until ack. The next grant is code=7.
- Set-wins and en gating: ack on code=3 while req[3]=1, en=1 -> pending[3] remains 1 and code=3 is regranted after the bubble. Repeat with en=0 -> pending[3] cleared and no regrant.
- Spurious ack: ack=1 while valid=0 with pending=0 -> no state change. Then req=8'h02 -> normal grant code=1 at 2-cycle latency.
